// File: rtl/bcd_to_unsigned_if.sv
// bcd_to_unsigned_if: trigger/idle handshake and result bus of the BCD to binary converter.
interface bcd_to_unsigned_if #(
    parameter int NDIGITS = 8,
    parameter int OUT_W   = 32
);
    logic                   trigger;
    logic [4*NDIGITS-1:0]   in;
    logic                   idle;
    logic                   done;
    logic [OUT_W-1:0]       out;
    logic                   err;
    modport master(output trigger, in, input idle, done, out, err);
    modport slave(input trigger, in, output idle, done, out, err);
endinterface

// File: rtl/bcd_to_unsigned.sv
// bcd_to_unsigned: sequential packed-BCD to binary, one digit per clock, MSD first.
// Optional BCD2U_DIGIT_CHECK_EN flags digits above 9 on err.
module bcd_to_unsigned #(
    parameter int NDIGITS = 8,
    parameter int OUT_W   = 32
) (
    input logic                clk,
    input logic                rst_n,
    bcd_to_unsigned_if.slave   bus
);
    localparam int CW = $clog2(NDIGITS + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t               state, state_nx;
    logic [4*NDIGITS-1:0] sh;
    logic [OUT_W-1:0]     acc, acc_nx, res;
    logic [CW-1:0]        cnt;
    logic [3:0]           d;
    logic                 last, start, step, done_q;
    always_comb begin
        d        = sh[4*NDIGITS-1 -: 4];
        acc_nx   = (acc << 3) + (acc << 1) + OUT_W'(d);
        last     = cnt == CW'(NDIGITS - 1);
        start    = state == IDLE && bus.trigger;
        step     = state == RUN;
        state_nx = start ? RUN : (step && last) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh     <= '0;
            acc    <= '0;
            cnt    <= '0;
            res    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= step && last;
            if (start) begin
                sh  <= bus.in;
                acc <= '0;
                cnt <= '0;
            end else if (step) begin
                sh  <= sh << 4;
                acc <= acc_nx;
                cnt <= cnt + CW'(1);
                if (last) res <= acc_nx;
            end
        end
    end
`ifdef BCD2U_DIGIT_CHECK_EN
    logic sticky, err_q, bad;
    assign bad = d > 4'd9;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
            err_q  <= 1'b0;
        end else if (start) begin
            sticky <= 1'b0;
        end else if (step) begin
            sticky <= sticky | bad;
            if (last) err_q <= sticky | bad;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
    assign bus.idle = state == IDLE;
    assign bus.done = done_q;
    assign bus.out  = res;
endmodule

// File: doc/bcd_to_unsigned.md
# bcd_to_unsigned

Sequential packed-BCD to unsigned-binary converter, the inverse of `unsigned_to_bcd`. It takes up to `NDIGITS` BCD digits, for example the HH/MM/SS fields of the clock's display word, and returns their binary value. Keypad time entry and alarm compare logic use it to get time values back into arithmetic form. It runs one multiply-accumulate step per clock, has a trigger/idle handshake matching `unsigned_to_bcd`, and holds its last result while converting.

## Interface
Parameters:
- `NDIGITS`, default 8: number of BCD digits in `in`. Legal range 1..9.
- `OUT_W`, default 32: width of `out`. Must satisfy 2^OUT_W > 10^NDIGITS − 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock, all state on its rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `trigger`  in  1: start request, sampled only while `idle`=1.
- `in`  in  4*NDIGITS: packed BCD, most significant digit in the top nibble.
- `idle`  out  1: 1 = ready to accept `trigger`.
- `done`  out  1: one-cycle pulse when `out` is updated.
- `out`  out  OUT_W: binary result of the last completed conversion.
- `err`  out  1: an invalid digit (>9) was seen in the last completed conversion.

## Operation
- States: IDLE and RUN.
- IDLE:
  - `idle`=1.
  - If `trigger`=1 on a rising edge:
    - latch `in` into the digit shift register;
    - clear the accumulator, digit counter and sticky error;
    - go to RUN.
- RUN:
  - `idle`=0.
  - Each cycle takes the top nibble `d` of the shift register and computes acc_next = acc*10 + d. acc*10 is formed as (acc<<3)+(acc<<1), truncated to OUT_W bits.
  - The shift register then shifts left one nibble and the counter increments.
  - After NDIGITS steps:
    - `out` <= acc_next;
    - `err` <= sticky error;
    - `done` <= 1 for one cycle;
    - return to IDLE.
- `out` and `err` change only at completion. They hold their previous values throughout RUN, so the output is glitch-free for display consumers.
- `trigger` and `in` are ignored during RUN; there is no queueing.
- `trigger` held high gives back-to-back conversions, each re-sampling `in` on its IDLE cycle.
- Arithmetic:
  - With legal OUT_W there is no overflow; 8 digits give at most 99,999,999 (27 bits).
  - An illegal OUT_W gives a result modulo 2^OUT_W; this is not flagged.
- Digits > 9 are used arithmetically as their raw value (0xA = 10, … 0xF = 15).

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - state = IDLE;
  - `idle`=1, `done`=0, `out`=0, `err`=0;
  - accumulator, counter and shift register all cleared.
- Reset during RUN aborts the conversion. No `done` is issued and `out` reads 0.
- Handshake: trigger accepted at edge k. Then:
  - `idle` is 0 from after edge k through edge k+NDIGITS;
  - `out` and `done` update at edge k+NDIGITS;
  - `idle`=1 again after edge k+NDIGITS.
- Latency is NDIGITS cycles from the accepting edge to a valid `out` (8 for the default).
- The earliest next acceptance is edge k+NDIGITS+1, so throughput is one conversion per NDIGITS+1 cycles (9 for the default).
- `done` is high for exactly the one cycle after the completion edge, coincident with the new `out` and with `idle` returning to 1.

## Configuration
- Macro `BCD2U_DIGIT_CHECK_EN`.
- Defined:
  - each RUN step ORs (d > 9) into the sticky error;
  - `err` reports it at completion;
  - `out` is still the raw arithmetic result.
- Not defined:
  - no compare logic is built;
  - `err` is tied to 0;
  - conversion behaviour is otherwise identical.

## Test plan
- Reset, then trigger with `in`=0x00000000: `idle` low for 8 cycles, then `done` pulses once, `out`=0, `err`=0.
- `in`=0x12345678, single trigger: after 8 cycles `out`=12345678 (0x00BC614E) and `done` pulses once. `out` holds its previous value until then.
- `in`=0x99999999: `out`=99999999 (0x05F5E0FF), `err`=0.
- Hold `trigger`=1 and change `in` from 0x00000059 to 0x00000023 mid-conversion:
  - first result is 59;
  - next result is 23, with `done` pulses 9 cycles apart;
  - the mid-conversion change of `in` does not corrupt the result in flight.
- `BCD2U_DIGIT_CHECK_EN` defined, `in`=0x0000001A: `out`=20 and `err`=1. A following conversion of 0x00000010 gives `out`=10 and `err`=0. With the macro undefined, `err` stays 0.
- Assert `rst_n`=0 at cycle 4 of a 0x12345678 conversion:
  - `out`=0, `idle`=1 immediately, and no `done` pulse;
  - after release, a new trigger converts correctly.
